// File: rtl/mips_pkg.sv
// Shared constants for the MIPS memory-mapped timer: register offsets, CTRL bit
// positions and the default base address of the 32-byte register window.
package mips_pkg;

   localparam logic [2:0] TMR_CTRL   = 3'd0;
   localparam logic [2:0] TMR_PRESC  = 3'd1;
   localparam logic [2:0] TMR_LOAD   = 3'd2;
   localparam logic [2:0] TMR_COUNT  = 3'd3;
   localparam logic [2:0] TMR_STATUS = 3'd4;

   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   localparam logic [31:0] TMR_BASE_ADDR = 32'h0000_0100;

endpackage

// File: rtl/mips_prescaler.sv
// Prescaler for the timer: counts enabled cycles and emits a one-cycle tick
// each time the running count matches the programmed prescale value.
module mips_prescaler #(
   parameter int PRESC_W = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               en,
   input  logic               restart,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] pcnt;

   // Equality compare: if PRESC is lowered below pcnt, pcnt runs up and wraps.
   assign tick = en && (pcnt == presc);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt <= '0;
      end else if (!en || restart || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/mips_timer_responder.sv
// Memory-mapped timer responder on the MIPS data bus: prescaled down-counter with
// auto-reload, sticky expiry flag and level interrupt; reads are combinational.
module mips_timer_responder
   import mips_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR = WIDTH'(TMR_BASE_ADDR),
   parameter int               PRESC_W   = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] WD,
   input  logic             WE,
   output logic [WIDTH-1:0] RD,
   output logic             HIT,
   output logic             IRQ
);

   logic               en, ar, ie, exp;
   logic [PRESC_W-1:0] presc;
   logic [WIDTH-1:0]   load, count;
   logic [2:0]         offset;
   logic               wr, wr_ctrl, wr_presc, wr_load, wr_count, wr_status;
   logic               tick, expire, restart;
   logic               unused_addr_bits;

   assign HIT    = (A[WIDTH-1:5] == BASE_ADDR[WIDTH-1:5]);
   assign offset = A[4:2];
   assign wr     = WE && HIT;

   assign wr_ctrl   = wr && (offset == TMR_CTRL);
   assign wr_presc  = wr && (offset == TMR_PRESC);
   assign wr_load   = wr && (offset == TMR_LOAD);
   assign wr_count  = wr && (offset == TMR_COUNT);
   assign wr_status = wr && (offset == TMR_STATUS);

   assign restart = wr_ctrl && WD[CTRL_EN] && !en;
   assign expire  = tick && (count == '0);
   assign IRQ     = exp && ie;

   assign unused_addr_bits = ^A[1:0];

   mips_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .CLK     (CLK),
      .RST     (RST),
      .en      (en),
      .restart (restart),
      .presc   (presc),
      .tick    (tick)
   );

   // CPU writes take priority over hardware updates of EN and COUNT;
   // a hardware expiry takes priority over a software clear of EXP.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         en    <= 1'b0;
         ar    <= 1'b0;
         ie    <= 1'b0;
         presc <= '0;
         load  <= '0;
         count <= '0;
         exp   <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en <= WD[CTRL_EN];
            ar <= WD[CTRL_AR];
            ie <= WD[CTRL_IE];
         end else if (expire && !ar) begin
            en <= 1'b0;
         end

         if (wr_presc) presc <= WD[PRESC_W-1:0];
         if (wr_load)  load  <= WD;

         if (wr_count) begin
            count <= WD;
         end else if (tick && (count != '0)) begin
            count <= count - WIDTH'(1);
         end else if (expire && ar) begin
            count <= load;
         end

         if (expire) begin
            exp <= 1'b1;
         end else if (wr_status && WD[0]) begin
            exp <= 1'b0;
         end
      end
   end

   // NOTE: RD gets a default before the case so the read mux never infers a latch.
   always_comb begin
      RD = '0;
      if (HIT) begin
         case (offset)
            TMR_CTRL:   RD = {{(WIDTH-3){1'b0}}, ie, ar, en};
            TMR_PRESC:  RD = {{(WIDTH-PRESC_W){1'b0}}, presc};
            TMR_LOAD:   RD = load;
            TMR_COUNT:  RD = count;
            TMR_STATUS: RD = {{(WIDTH-1){1'b0}}, exp};
            default:    RD = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_timer_responder.sv
// Self-checking bench for mips_timer_responder: register table, directed timing
// sequences and a randomized run against a cycle-level reference model.
module tb_mips_timer_responder;
   import mips_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a  = BASE;
   logic [31:0] wd = '0;
   logic        we = 1'b0;
   logic [31:0] rd;
   logic        hit, irq;

   int total = 0;
   int bad   = 0;

   always #10 clk = ~clk;

   mips_timer_responder dut (
      .CLK (clk),
      .RST (rst),
      .A   (a),
      .WD  (wd),
      .WE  (we),
      .RD  (rd),
      .HIT (hit),
      .IRQ (irq)
   );

   // Reference model state, advanced once per rising edge.
   bit          m_en, m_ar, m_ie, m_exp;
   int unsigned m_presc, m_pcnt;
   logic [31:0] m_load, m_count;

   typedef struct {
      bit          do_write;
      logic [2:0]  off;
      logic [31:0] data;
      logic [31:0] want;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic logic [31:0] reg_addr(input logic [2:0] off);
      return BASE + {27'd0, off, 2'b00};
   endfunction

   task automatic read_chk(input string name, input logic [2:0] off, input logic [31:0] want);
      a  = reg_addr(off);
      we = 1'b0;
      #1;
      check(name, rd, want);
   endtask

   task automatic drive_write(input logic [2:0] off, input logic [31:0] data);
      a  = reg_addr(off);
      wd = data;
      we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] data);
      @(negedge clk);
      drive_write(off, data);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      we  = 1'b0;
      a   = BASE;
      wd  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
      m_presc = 0; m_pcnt = 0; m_load = '0; m_count = '0;
   endtask

   function automatic bit model_hit(input logic [31:0] addr);
      return (addr >> 5) == (BASE >> 5);
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] addr);
      int off;
      if (!model_hit(addr)) return '0;
      off = int'((addr >> 2) % 8);
      case (off)
         0:       return {29'd0, m_ie, m_ar, m_en};
         1:       return m_presc;
         2:       return m_load;
         3:       return m_count;
         4:       return {31'd0, m_exp};
         default: return '0;
      endcase
   endfunction

   // One clock edge of the timer, computed from the pre-edge model state.
   task automatic model_step(input logic [31:0] addr, input logic [31:0] data, input bit w);
      bit          wr_m, tick_m, fire, n_en, n_ar, n_ie, n_exp;
      int          off;
      int unsigned n_pcnt, n_presc;
      logic [31:0] n_load, n_count;
      wr_m   = w && model_hit(addr);
      off    = int'((addr >> 2) % 8);
      tick_m = m_en && (m_pcnt == m_presc);
      fire   = tick_m && (m_count == 0);
      n_pcnt = (!m_en || tick_m) ? 0 : (m_pcnt + 1) % 65536;
      n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_exp = m_exp;
      n_presc = m_presc; n_load = m_load; n_count = m_count;
      if (tick_m) begin
         if (m_count != 0) n_count = m_count - 1;
         else if (m_ar)    n_count = m_load;
         else              n_en = 0;
      end
      if (wr_m && off == 4 && data[0]) n_exp = 0;
      if (fire) n_exp = 1;
      if (wr_m) begin
         case (off)
            0: begin
               if (data[0] && !m_en) n_pcnt = 0;
               n_en = data[0]; n_ar = data[1]; n_ie = data[2];
            end
            1: n_presc = data % 65536;
            2: n_load  = data;
            3: n_count = data;
            default: ;
         endcase
      end
      m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_exp = n_exp;
      m_pcnt = n_pcnt; m_presc = n_presc; m_load = n_load; m_count = n_count;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr, data;
      bit          w;
      int          off;

      vecs[0] = '{1'b1, TMR_LOAD,   32'h0000_1234, 32'h0000_1234};
      vecs[1] = '{1'b1, TMR_PRESC,  32'hABCD_1234, 32'h0000_1234};
      vecs[2] = '{1'b1, TMR_COUNT,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, TMR_CTRL,   32'hFFFF_FFF8, 32'h0000_0000};
      vecs[4] = '{1'b1, 3'd5,       32'hFFFF_FFFF, 32'h0000_0000};
      vecs[5] = '{1'b0, 3'd6,       32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{1'b0, 3'd7,       32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{1'b1, TMR_STATUS, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[8] = '{1'b0, TMR_LOAD,   32'h0000_0000, 32'h0000_1234};

      // Reset state and register table
      do_reset();
      @(negedge clk);
      read_chk("rst_ctrl",   TMR_CTRL,   '0);
      read_chk("rst_count",  TMR_COUNT,  '0);
      read_chk("rst_status", TMR_STATUS, '0);
      check("rst_irq", 32'(irq), 32'd0);
      foreach (vecs[i]) begin
         if (vecs[i].do_write) wr(vecs[i].off, vecs[i].data);
         @(negedge clk);
         read_chk($sformatf("vec%0d", i), vecs[i].off, vecs[i].want);
      end

      // Address decode
      @(negedge clk);
      a = BASE + 32 + 8; #1;
      check("miss_above_hit", 32'(hit), 32'd0);
      check("miss_above_rd", rd, 32'd0);
      a = BASE - 24; #1;
      check("miss_below_hit", 32'(hit), 32'd0);
      a = BASE + 8 + 3; #1;
      check("byte_bits_hit", 32'(hit), 32'd1);
      check("byte_bits_rd", rd, 32'h0000_1234);

      // One-shot expiry
      do_reset();
      wr(TMR_PRESC, 0);
      wr(TMR_COUNT, 3);
      wr(TMR_CTRL, 32'h5);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         read_chk($sformatf("oneshot_count%0d", k), TMR_COUNT, 32'(3 - k));
      end
      check("oneshot_irq_before", 32'(irq), 32'd0);
      @(negedge clk);
      read_chk("oneshot_exp",   TMR_STATUS, 32'd1);
      read_chk("oneshot_en",    TMR_CTRL,   32'h4);
      read_chk("oneshot_count", TMR_COUNT,  32'd0);
      check("oneshot_irq", 32'(irq), 32'd1);

      // COUNT write on a tick cycle
      do_reset();
      wr(TMR_PRESC, 0);
      wr(TMR_COUNT, 10);
      wr(TMR_CTRL, 32'h1);
      @(negedge clk);
      read_chk("wprio_start", TMR_COUNT, 32'd10);
      drive_write(TMR_COUNT, 100);
      @(negedge clk);
      read_chk("wprio_count", TMR_COUNT, 32'd100);
      @(negedge clk);
      read_chk("wprio_next", TMR_COUNT, 32'd99);

      // CTRL write on one-shot expiry cycle
      do_reset();
      wr(TMR_PRESC, 0);
      wr(TMR_COUNT, 1);
      wr(TMR_CTRL, 32'h1);
      repeat (2) @(negedge clk);
      drive_write(TMR_CTRL, 32'h3);
      @(negedge clk);
      read_chk("ctrl_prio_en",  TMR_CTRL,   32'h3);
      read_chk("ctrl_prio_exp", TMR_STATUS, 32'd1);

      // Auto-reload with prescale, clear collision, async reset
      do_reset();
      wr(TMR_PRESC, 2);
      wr(TMR_LOAD, 4);
      wr(TMR_COUNT, 4);
      wr(TMR_CTRL, 32'h7);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         read_chk("ar_first_exp", TMR_STATUS, 32'(k == 16));
      end
      read_chk("ar_reload1", TMR_COUNT, 32'd4);
      check("ar_irq", 32'(irq), 32'd1);
      wr(TMR_STATUS, 1);
      for (int k = 18; k <= 30; k++) begin
         @(negedge clk);
         read_chk("ar_cleared", TMR_STATUS, 32'd0);
      end
      drive_write(TMR_STATUS, 1);
      @(negedge clk);
      read_chk("clr_collision", TMR_STATUS, 32'd1);
      drive_write(TMR_STATUS, 1);
      @(negedge clk);
      read_chk("clr_later", TMR_STATUS, 32'd0);
      check("clr_later_irq", 32'(irq), 32'd0);
      for (int k = 33; k <= 46; k++) begin
         @(negedge clk);
         read_chk("ar_period", TMR_STATUS, 32'(k == 46));
      end
      read_chk("ar_reload2", TMR_COUNT, 32'd4);
      @(negedge clk);
      check("pre_rst_irq", 32'(irq), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_irq", 32'(irq), 32'd0);
      read_chk("async_rst_ctrl",   TMR_CTRL,   '0);
      read_chk("async_rst_presc",  TMR_PRESC,  '0);
      read_chk("async_rst_load",   TMR_LOAD,   '0);
      read_chk("async_rst_count",  TMR_COUNT,  '0);
      read_chk("async_rst_status", TMR_STATUS, '0);
      @(negedge clk);
      rst = 1'b0;

      // Prescaler lowered below the running pcnt: pcnt wraps before the next tick
      do_reset();
      wr(TMR_PRESC, 5);
      wr(TMR_COUNT, 50);
      wr(TMR_CTRL, 32'h1);
      repeat (5) @(negedge clk);
      drive_write(TMR_PRESC, 1);
      repeat (2) @(negedge clk);
      read_chk("presc_no_tick", TMR_COUNT, 32'd50);
      repeat (65538 - 7) @(negedge clk);
      read_chk("presc_wrap_hold", TMR_COUNT, 32'd50);
      @(negedge clk);
      read_chk("presc_wrap_tick", TMR_COUNT, 32'd49);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         off = int'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         else addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
         w = ($urandom_range(0, 3) == 0);
         case (off)
            1:       data = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
            2, 3:    data = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 6));
            default: data = $urandom;
         endcase
         a = addr; wd = data; we = w;
         #1;
         check("rand_rd",  rd,        model_rd(addr));
         check("rand_hit", 32'(hit),  32'(model_hit(addr)));
         check("rand_irq", 32'(irq),  32'(m_exp && m_ie));
         @(posedge clk);
         model_step(addr, data, w);
         #1;
         we = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
